// File: rtl/word_byte_serializer_if.sv
// Handshake bundle for the word-to-byte serializer: word input side and byte output side.
// The slave modport is the serializer's view; the master modport is the view of whatever drives it.
interface word_byte_serializer_if #(
   parameter int BYTE_SIZE   = 8,
   parameter int INPUT_BYTES = 4
);
   logic [INPUT_BYTES*BYTE_SIZE-1:0] s_data;
   logic                             s_valid;
   logic                             s_ready;
   logic                             s_last;
   logic                             big_endian;
   logic [BYTE_SIZE-1:0]             m_data;
   logic                             m_valid;
   logic                             m_ready;
   logic                             m_last;
   logic                             busy;

   modport slave (
      input  s_data, s_valid, s_last, big_endian, m_ready,
      output s_ready, m_data, m_valid, m_last, busy
   );

   modport master (
      output s_data, s_valid, s_last, big_endian, m_ready,
      input  s_ready, m_data, m_valid, m_last, busy
   );
endinterface

// File: rtl/word_byte_serializer.sv
// Splits each accepted word into INPUT_BYTES bytes, emitted MSB- or LSB-first as latched
// with the word; a new word can be taken on the edge that sends the last byte (no bubble).
module word_byte_serializer #(
   parameter int BYTE_SIZE   = 8,
   parameter int INPUT_BYTES = 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   word_byte_serializer_if.slave   bus
);
   localparam int               IDX_W    = $clog2(INPUT_BYTES);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_BYTES-1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t                           r_state;
   state_t                           w_next;
   logic [INPUT_BYTES*BYTE_SIZE-1:0] r_word;
   logic                             r_last;
   logic                             r_be;
   logic [IDX_W-1:0]                 r_idx;
   logic [IDX_W-1:0]                 w_sel;
   logic                             w_accept;
   logic                             w_xfer;
   logic                             w_last_byte;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next       = r_state;
      w_sel        = r_idx;
      w_xfer       = 1'b0;
      w_last_byte  = (r_idx == LAST_IDX);
      bus.s_ready  = 1'b0;
      bus.m_valid  = 1'b0;
      bus.m_last   = 1'b0;
      bus.m_data   = '0;
      bus.busy     = 1'b0;
      case (r_state)
         IDLE: begin
            bus.s_ready = rst_n;
         end
         SHIFT: begin
            bus.m_valid = 1'b1;
            bus.busy    = 1'b1;
            w_sel       = r_be ? (LAST_IDX - r_idx) : r_idx;
            bus.m_data  = r_word[int'(w_sel)*BYTE_SIZE +: BYTE_SIZE];
            bus.m_last  = r_last & w_last_byte;
            w_xfer      = bus.m_ready;
            // Final byte leaving this edge frees the word register for a fresh word.
            bus.s_ready = rst_n & w_last_byte & bus.m_ready;
            if (w_xfer && w_last_byte) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      w_accept = bus.s_valid & bus.s_ready;
      if (w_accept) w_next = SHIFT;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_word <= '0;
         r_last <= 1'b0;
         r_be   <= 1'b0;
         r_idx  <= '0;
      end else if (w_accept) begin
         r_word <= bus.s_data;
         r_last <= bus.s_last;
         r_be   <= bus.big_endian;
         r_idx  <= '0;
      end else if (w_xfer) begin
         r_idx  <= w_last_byte ? '0 : r_idx + 1'b1;
      end
   end
endmodule
